// File: rtl/cla_result_fifo.sv
// First-word-fall-through result FIFO behind a clocked CLA stage.
// Each entry holds {carry, sum}. Entries offered while the FIFO is full are dropped and flagged in a sticky ovf.
module cla_result_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_s,
  input  logic              in_co,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_s,
  output logic              out_co,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              ovf
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               push_s, pop_s, full_s, empty_s;
  logic [DATA_W:0]    head_s;

  // Status comes only from the registered count, so in_valid never reaches full/empty.
  always_comb begin
    empty_s  = (count_q == {CNT_W{1'b0}});
    full_s   = (count_q == CNT_W'(DEPTH));
    pop_s    = (!empty_s) && out_ready;
    push_s   = in_valid && ((!full_s) || pop_s);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (in_valid & full_s & ~pop_s);
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer, occupancy and sticky overflow state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is left unreset; the empty gating below keeps outputs clean.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {in_co, in_s};
    end
  end

  // Head entry falls through, forced to zero while empty.
  always_comb begin
    head_s = mem_q[rd_ptr_q];
    if (empty_s) begin
      out_s  = {DATA_W{1'b0}};
      out_co = 1'b0;
    end else begin
      out_s  = head_s[DATA_W-1:0];
      out_co = head_s[DATA_W];
    end
    out_valid = !empty_s;
    full      = full_s;
    empty     = empty_s;
    count     = count_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_cla_result_fifo.sv
// Directed self-checking bench for cla_result_fifo (DATA_W=32, DEPTH=4).
module tb_cla_result_fifo;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_s;
  logic        in_co;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_s;
  logic        out_co;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic        ovf;

  int n_vec = 0;
  int n_err = 0;

  cla_result_fifo #(.DATA_W(32), .DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_s(in_s), .in_co(in_co),
    .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s), .out_co(out_co),
    .full(full), .empty(empty), .count(count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] s, input logic co);
    in_valid = 1'b1;
    in_s     = s;
    in_co    = co;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] s, input logic co);
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_s"}, {32'd0, out_s}, {32'd0, s});
    chk({tag, "_co"}, {63'd0, out_co}, {63'd0, co});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [31:0] vs [4];
  logic        vc [4];

  initial begin
    vs[0] = 32'h00010010; vc[0] = 1'b0;
    vs[1] = 32'h00000001; vc[1] = 1'b1;
    vs[2] = 32'hFFFFFFFF; vc[2] = 1'b0;
    vs[3] = 32'h1A354FAA; vc[3] = 1'b0;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_s      = 32'd0;
    in_co     = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    // Reset state
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_empty", {63'd0, empty}, 64'd1);
    chk("rst_full",  {63'd0, full}, 64'd0);
    chk("rst_count", {61'd0, count}, 64'd0);
    chk("rst_s",     {32'd0, out_s}, 64'd0);
    chk("rst_co",    {63'd0, out_co}, 64'd0);
    chk("rst_ovf",   {63'd0, ovf}, 64'd0);
    reset_n = 1'b1;

    // Ready while empty must not underflow or move the read pointer
    out_ready = 1'b1;
    tick();
    tick();
    chk("udf_count", {61'd0, count}, 64'd0);
    chk("udf_empty", {63'd0, empty}, 64'd1);
    out_ready = 1'b0;

    // Fill four then drain in order
    for (int i = 0; i < 4; i++) push_one(vs[i], vc[i]);
    chk("fill_full",  {63'd0, full}, 64'd1);
    chk("fill_count", {61'd0, count}, 64'd4);
    for (int i = 0; i < 4; i++) pop_expect($sformatf("order%0d", i), vs[i], vc[i]);
    chk("drain_empty", {63'd0, empty}, 64'd1);
    chk("drain_s",     {32'd0, out_s}, 64'd0);

    // Overflow: drop while full, sticky after drain
    for (int i = 0; i < 4; i++) push_one(32'h100 + 32'(i), 1'b0);
    push_one(32'h12345678, 1'b1);
    chk("ovf_set",   {63'd0, ovf}, 64'd1);
    chk("ovf_count", {61'd0, count}, 64'd4);
    for (int i = 0; i < 4; i++) pop_expect($sformatf("ovf_pop%0d", i), 32'h100 + 32'(i), 1'b0);
    chk("ovf_empty",  {63'd0, empty}, 64'd1);
    chk("ovf_sticky", {63'd0, ovf}, 64'd1);

    reset_n = 1'b0;
    #2;
    chk("ovf_clr", {63'd0, ovf}, 64'd0);
    reset_n = 1'b1;
    tick();

    // Push and pop together while full
    for (int i = 0; i < 4; i++) push_one(32'h200 + 32'(i), 1'b0);
    chk("fpp_head0", {32'd0, out_s}, 64'h200);
    in_valid  = 1'b1;
    in_s      = 32'hA5A5A5A5;
    in_co     = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("fpp_count", {61'd0, count}, 64'd4);
    chk("fpp_ovf",   {63'd0, ovf}, 64'd0);
    for (int i = 1; i < 4; i++) pop_expect($sformatf("fpp_pop%0d", i), 32'h200 + 32'(i), 1'b0);
    pop_expect("fpp_new", 32'hA5A5A5A5, 1'b1);
    chk("fpp_empty", {63'd0, empty}, 64'd1);

    // Streaming: count stays 1, head is the value pushed at the last edge
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_s  = 32'h300 + 32'(i);
      in_co = i[0];
      tick();
      chk($sformatf("str_count%0d", i), {61'd0, count}, 64'd1);
      chk($sformatf("str_valid%0d", i), {63'd0, out_valid}, 64'd1);
      chk($sformatf("str_s%0d", i), {32'd0, out_s}, {32'd0, 32'h300 + 32'(i)});
      chk($sformatf("str_co%0d", i), {63'd0, out_co}, {63'd0, i[0]});
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("str_empty", {63'd0, empty}, 64'd1);
    chk("str_ovf",   {63'd0, ovf}, 64'd0);

    // Async reset pulse between edges with three entries held
    for (int i = 0; i < 3; i++) push_one(32'h500 + 32'(i), 1'b1);
    chk("ar_count3", {61'd0, count}, 64'd3);
    #1;
    reset_n = 1'b0;
    #1;
    chk("ar_valid", {63'd0, out_valid}, 64'd0);
    chk("ar_count", {61'd0, count}, 64'd0);
    chk("ar_s",     {32'd0, out_s}, 64'd0);
    #2;
    reset_n = 1'b1;
    tick();
    push_one(32'h400, 1'b0);
    chk("ar_count1", {61'd0, count}, 64'd1);
    pop_expect("ar_head", 32'h400, 1'b0);
    chk("ar_empty", {63'd0, empty}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
